// File: rtl/junction_sequencer.sv
// Rover navigation sequencer: debounces the rover sensors, line-follows between junctions and
// sequences timed branch turns and cone U-turns onto the registered motor driver pins.
module junction_sequencer #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int TURN_MIN     = 1000,
  parameter int UTURN_MIN    = 4000,
  parameter int TIMEOUT      = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [2:0] induct,
  input  logic       proxim,
  input  logic       red,
  output logic [3:0] motorIn,
  output logic [1:0] motorEn,
  output logic       fault,
  output logic       cone_flag,
  output logic [2:0] state_dbg
);

  localparam logic [3:0] MOT_FWD   = 4'b0110;
  localparam logic [3:0] MOT_LEFT  = 4'b1010;
  localparam logic [3:0] MOT_RIGHT = 4'b0101;
  localparam logic [3:0] MOT_OFF   = 4'b0000;

  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  // Bit order {red, proxim, induct[2:0]}; idle values are red=0, proxim=0, induct=111.
  localparam logic [4:0] DEB_RST = 5'b00111;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FOLLOW   = 3'd1,
    S_JUNCTION = 3'd2,
    S_TURN     = 3'd3,
    S_UTURN    = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  logic [4:0] raw_bits;
  logic [4:0] deb_bits;

  assign raw_bits = {red, proxim, induct};

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_deb
      logic [DBW-1:0] cnt_reg;
      logic           deb_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
          deb_reg <= DEB_RST[gi];
        end else if (raw_bits[gi] == deb_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DBW'(DEBOUNCE_CYC - 1)) begin
          cnt_reg <= '0;
          deb_reg <= raw_bits[gi];
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign deb_bits[gi] = deb_reg;
    end
  endgenerate

  logic [2:0] deb_induct;
  logic       deb_proxim;
  logic       deb_red;

  assign deb_induct = deb_bits[2:0];
  assign deb_proxim = deb_bits[3];
  assign deb_red    = deb_bits[4];

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic [3:0]    motor_in_reg;
  logic [1:0]    motor_en_reg;
  logic [3:0]    last_dir_reg;
  logic          fault_reg;
  logic          cone_reg;
  logic          branch_reg;
  logic          red_prev_reg;
  logic          red_rise;

  assign red_rise = deb_red & ~red_prev_reg;

  // Line-follow steering: lost-line and ambiguous patterns keep the last steering direction.
  function automatic logic [3:0] follow_dir(input logic [2:0] ind, input logic [3:0] last);
    logic [3:0] dir;
    dir = last;
    case (ind)
      3'b011, 3'b001: dir = MOT_LEFT;
      3'b110, 3'b100: dir = MOT_RIGHT;
      3'b101:         dir = MOT_FWD;
      default:        dir = last;
    endcase
    return dir;
  endfunction

  // Outputs are loaded with the pattern of the state being entered, so they stay aligned with state_dbg.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      timer_reg    <= '0;
      motor_in_reg <= MOT_OFF;
      motor_en_reg <= 2'b00;
      last_dir_reg <= MOT_FWD;
      fault_reg    <= 1'b0;
      cone_reg     <= 1'b0;
      branch_reg   <= 1'b0;
      red_prev_reg <= 1'b0;
    end else begin
      red_prev_reg <= deb_red;
      if (timer_reg != TW'(TIMEOUT)) begin
        timer_reg <= timer_reg + 1'b1;
      end

      if (state_reg != S_FAULT && !run) begin
        state_reg    <= S_IDLE;
        timer_reg    <= '0;
        motor_in_reg <= MOT_OFF;
        motor_en_reg <= 2'b00;
      end else begin
        case (state_reg)
          S_IDLE: begin
            state_reg    <= S_FOLLOW;
            timer_reg    <= '0;
            motor_in_reg <= follow_dir(deb_induct, last_dir_reg);
            motor_en_reg <= 2'b11;
          end

          S_FOLLOW: begin
            last_dir_reg <= follow_dir(deb_induct, last_dir_reg);
            if (deb_proxim) begin
              state_reg    <= S_UTURN;
              timer_reg    <= '0;
              cone_reg     <= 1'b1;
              motor_in_reg <= MOT_LEFT;
            end else if (red_rise) begin
              state_reg <= S_JUNCTION;
              timer_reg <= '0;
            end else begin
              motor_in_reg <= follow_dir(deb_induct, last_dir_reg);
            end
          end

          S_JUNCTION: begin
            state_reg <= S_TURN;
            timer_reg <= '0;
            if (!cone_reg) begin
              branch_reg   <= ~branch_reg;
              motor_in_reg <= branch_reg ? MOT_LEFT : MOT_RIGHT;
            end else begin
              // After a cone the untried branch is the one already selected.
              cone_reg     <= 1'b0;
              motor_in_reg <= branch_reg ? MOT_RIGHT : MOT_LEFT;
            end
          end

          S_TURN: begin
            if (timer_reg >= TW'(TURN_MIN) && !deb_induct[1]) begin
              state_reg    <= S_FOLLOW;
              timer_reg    <= '0;
              last_dir_reg <= MOT_FWD;
              motor_in_reg <= follow_dir(deb_induct, MOT_FWD);
            end else if (timer_reg == TW'(TIMEOUT)) begin
              state_reg    <= S_FAULT;
              timer_reg    <= '0;
              fault_reg    <= 1'b1;
              motor_in_reg <= MOT_OFF;
              motor_en_reg <= 2'b00;
            end
          end

          S_UTURN: begin
            if (timer_reg >= TW'(UTURN_MIN) && !deb_induct[1]) begin
              state_reg    <= S_FOLLOW;
              timer_reg    <= '0;
              motor_in_reg <= follow_dir(deb_induct, last_dir_reg);
            end else if (timer_reg == TW'(TIMEOUT)) begin
              state_reg    <= S_FAULT;
              timer_reg    <= '0;
              fault_reg    <= 1'b1;
              motor_in_reg <= MOT_OFF;
              motor_en_reg <= 2'b00;
            end
          end

          S_FAULT: begin
            if (!run) begin
              state_reg <= S_IDLE;
              timer_reg <= '0;
              fault_reg <= 1'b0;
            end
          end

          default: begin
            state_reg    <= S_IDLE;
            timer_reg    <= '0;
            fault_reg    <= 1'b0;
            motor_in_reg <= MOT_OFF;
            motor_en_reg <= 2'b00;
          end
        endcase
      end
    end
  end

  assign motorIn   = motor_in_reg;
  assign motorEn   = motor_en_reg;
  assign fault     = fault_reg;
  assign cone_flag = cone_reg;
  assign state_dbg = state_reg;

endmodule

// File: tb/tb_junction_sequencer.sv
// Scoreboard bench for junction_sequencer: each stimulus step queues the output transitions it
// should cause, and a negedge monitor pops and compares them (value and cycle) as they appear.
module tb_junction_sequencer;

  localparam logic [3:0] FWD   = 4'b0110;
  localparam logic [3:0] LEFT  = 4'b1010;
  localparam logic [3:0] RIGHT = 4'b0101;
  localparam logic [3:0] OFF   = 4'b0000;
  localparam int DEB_LAT = 17;  // raw change to motor/state response

  logic       clk = 1'b0;
  logic       reset, run, proxim, red;
  logic [2:0] induct;
  logic [3:0] motorIn;
  logic [1:0] motorEn;
  logic       fault, cone_flag;
  logic [2:0] state_dbg;

  junction_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .induct    (induct),
    .proxim    (proxim),
    .red       (red),
    .motorIn   (motorIn),
    .motorEn   (motorEn),
    .fault     (fault),
    .cone_flag (cone_flag),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          at;
    logic [10:0] outs;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic        mon_en = 1'b0;
  logic [10:0] prev_outs;
  logic [10:0] outs;

  assign outs = {state_dbg, motorIn, motorEn, fault, cone_flag};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int at, input logic [2:0] st,
                          input logic [3:0] mi, input logic [1:0] me, input logic f,
                          input logic cf);
    exp_t e;
    e.tag  = tag;
    e.at   = at;
    e.outs = {st, mi, me, f, cf};
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en && outs !== prev_outs) begin
      if (sb.size() == 0) begin
        check_val("unexpected_change", 32'(outs), 32'(prev_outs));
      end else begin
        mon_e = sb.pop_front();
        $display("[%0d] %s state=%0d motorIn=%b motorEn=%b fault=%b cone=%b", cyc, mon_e.tag,
                 state_dbg, motorIn, motorEn, fault, cone_flag);
        check_val({mon_e.tag, "_outs"}, 32'(outs), 32'(mon_e.outs));
        check_val({mon_e.tag, "_cyc"}, cyc, mon_e.at);
      end
      prev_outs = outs;
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Red marker pulse with the line centred: junction, turn, and re-acquisition after TURN_MIN.
  task automatic junction_turn(input string tag, input logic cone_before, input logic [3:0] turn_mi);
    int c;
    c = cyc;
    red = 1'b1;
    push_exp({tag, "_junc"}, c + DEB_LAT, 3'd2, FWD, 2'b11, 1'b0, cone_before);
    push_exp({tag, "_turn"}, c + DEB_LAT + 1, 3'd3, turn_mi, 2'b11, 1'b0, 1'b0);
    push_exp({tag, "_exit"}, c + DEB_LAT + 1 + 1001, 3'd1, FWD, 2'b11, 1'b0, 1'b0);
    wait_until(c + 40);
    red = 1'b0;
    wait_until(c + DEB_LAT + 1 + 1001 + 5);
  endtask

  typedef struct {
    logic [2:0] ind;
    logic       chg;
    logic [3:0] mi;
  } dir_t;

  dir_t dir_tab[4] = '{
    '{3'b011, 1'b1, LEFT},
    '{3'b111, 1'b0, LEFT},
    '{3'b110, 1'b1, RIGHT},
    '{3'b101, 1'b1, FWD}
  };

  initial begin
    int c;
    int e;

    reset = 1'b1; run = 1'b0; induct = 3'b111; proxim = 1'b0; red = 1'b0;
    idle_cycles(3);
    reset = 1'b0;
    idle_cycles(1);
    check_val("rst_state", 32'(state_dbg), 32'd0);
    check_val("rst_motorIn", 32'(motorIn), 32'(OFF));
    check_val("rst_motorEn", 32'(motorEn), 32'd0);
    check_val("rst_fault", 32'(fault), 32'd0);
    check_val("rst_cone", 32'(cone_flag), 32'd0);
    prev_outs = outs;
    mon_en = 1'b1;

    // T1: start following with the line centred.
    c = cyc; run = 1'b1; induct = 3'b101;
    push_exp("t1_follow", c + 1, 3'd1, FWD, 2'b11, 1'b0, 1'b0);
    idle_cycles(20);

    // Steering table; lost line (111) keeps the previous direction.
    for (int i = 0; i < 4; i++) begin
      c = cyc; induct = dir_tab[i].ind;
      if (dir_tab[i].chg)
        push_exp($sformatf("dir%0d", i), c + DEB_LAT, 3'd1, dir_tab[i].mi, 2'b11, 1'b0, 1'b0);
      idle_cycles(20);
    end

    // T2: sensor chatter shorter than the debounce window must not move the motors.
    for (int i = 0; i < 8; i++) begin
      induct = (i % 2 == 0) ? 3'b011 : 3'b101;
      idle_cycles(5);
    end
    idle_cycles(20);
    check_val("t2_motorIn", 32'(motorIn), 32'(FWD));

    // run=0 stops, run=1 restarts.
    c = cyc; run = 1'b0;
    push_exp("stop_idle", c + 1, 3'd0, OFF, 2'b00, 1'b0, 1'b0);
    idle_cycles(3);
    c = cyc; run = 1'b1;
    push_exp("restart", c + 1, 3'd1, FWD, 2'b11, 1'b0, 1'b0);
    idle_cycles(20);

    // T3: first junction goes right; an early line sighting is ignored before TURN_MIN.
    c = cyc; red = 1'b1; induct = 3'b111;
    push_exp("t3_junc", c + DEB_LAT, 3'd2, FWD, 2'b11, 1'b0, 1'b0);
    push_exp("t3_turn", c + DEB_LAT + 1, 3'd3, RIGHT, 2'b11, 1'b0, 1'b0);
    e = c + DEB_LAT + 1;
    wait_until(c + 40); red = 1'b0;
    wait_until(e + 480); induct = 3'b101;
    wait_until(e + 520); induct = 3'b111;
    wait_until(e + 1200); induct = 3'b101;
    push_exp("t3_exit", e + 1200 + DEB_LAT, 3'd1, FWD, 2'b11, 1'b0, 1'b0);
    wait_until(e + 1225);

    // T4: cone -> U-turn for exactly UTURN_MIN+1 edges, then same-branch turn clears cone_flag.
    c = cyc; proxim = 1'b1;
    push_exp("t4_uturn", c + DEB_LAT, 3'd4, LEFT, 2'b11, 1'b0, 1'b1);
    e = c + DEB_LAT;
    wait_until(c + 20); proxim = 1'b0;
    push_exp("t4_exit", e + 4001, 3'd1, FWD, 2'b11, 1'b0, 1'b1);
    wait_until(e + 4010);
    junction_turn("t4j", 1'b1, RIGHT);

    // T5: red edge and cone together: cone wins, branch selection untouched.
    c = cyc; red = 1'b1; proxim = 1'b1;
    push_exp("t5_uturn", c + DEB_LAT, 3'd4, LEFT, 2'b11, 1'b0, 1'b1);
    e = c + DEB_LAT;
    wait_until(c + 40); red = 1'b0; proxim = 1'b0;
    push_exp("t5_exit", e + 4001, 3'd1, FWD, 2'b11, 1'b0, 1'b1);
    wait_until(e + 4010);
    junction_turn("t5j", 1'b1, RIGHT);

    // T6: turn with no line -> FAULT at the timeout, then recover and reset mid-U-turn.
    c = cyc; red = 1'b1; induct = 3'b111;
    push_exp("t6_junc", c + DEB_LAT, 3'd2, FWD, 2'b11, 1'b0, 1'b0);
    push_exp("t6_turn", c + DEB_LAT + 1, 3'd3, LEFT, 2'b11, 1'b0, 1'b0);
    e = c + DEB_LAT + 1;
    wait_until(c + 40); red = 1'b0;
    push_exp("t6_fault", e + 50001, 3'd5, OFF, 2'b00, 1'b1, 1'b0);
    wait_until(e + 50006);
    c = cyc; run = 1'b0;
    push_exp("t6_idle", c + 1, 3'd0, OFF, 2'b00, 1'b0, 1'b0);
    idle_cycles(5);
    c = cyc; run = 1'b1; induct = 3'b101;
    push_exp("t6_follow", c + 1, 3'd1, FWD, 2'b11, 1'b0, 1'b0);
    idle_cycles(20);
    c = cyc; proxim = 1'b1;
    push_exp("t6_uturn", c + DEB_LAT, 3'd4, LEFT, 2'b11, 1'b0, 1'b1);
    wait_until(c + DEB_LAT + 100);
    c = cyc; reset = 1'b1;
    push_exp("t6_reset", c + 1, 3'd0, OFF, 2'b00, 1'b0, 1'b0);
    idle_cycles(3);
    reset = 1'b0; run = 1'b0; proxim = 1'b0;
    idle_cycles(3);

    check_val("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
